// File: rtl/micro_tile_scheduler_if.sv
// Bundle of config, tile-side and pad-bus signals between the micro-tile array
// and the time-slice scheduler.
interface micro_tile_scheduler_if #(
  parameter int N_TILES = 4
);
  localparam int SEL_W = $clog2(N_TILES);

  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [7:0]             cfg_wdata;
  logic [N_TILES-1:0]     tile_req;
  logic [8*N_TILES-1:0]   tile_out;
  logic [N_TILES-1:0]     tile_grant;
  logic [N_TILES-1:0]     tile_rst;
  logic [SEL_W-1:0]       sel;
  logic                   busy;
  logic [7:0]             bus_out;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, tile_req, tile_out,
    input  tile_grant, tile_rst, sel, busy, bus_out
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, tile_req, tile_out,
    output tile_grant, tile_rst, sel, busy, bus_out
  );
endinterface

// File: rtl/micro_tile_scheduler.sv
// Round-robin time-slice scheduler: one tile at a time is released from reset
// and drives the shared 8-bit pad bus for a programmable dwell period.
module micro_tile_scheduler #(
  parameter int N_TILES     = 4,
  parameter int DWELL_W     = 8,
  parameter int PREP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  micro_tile_scheduler_if.slave  io
);
  localparam int SEL_W = $clog2(N_TILES);
  localparam int PC_W  = $clog2(PREP_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]         state;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   ptr;
  logic [PC_W-1:0]    prep_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_len;
  logic [N_TILES-1:0] enable_mask;
  logic [N_TILES-1:0] eligible;
  logic [SEL_W:0]     pick;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [7:0]         bus_p1;

  // First eligible tile after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_TILES-1:0] elig,
                                             input logic [SEL_W-1:0]   last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = N_TILES; k >= 1; k--) begin
      idx = SEL_W'((int'(last) + k) % N_TILES);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [7:0] w);
    logic [DWELL_W-1:0] v;
    v = DWELL_W'(w);
    return (v == '0) ? DWELL_W'(1) : v;
  endfunction

  always_comb begin
    eligible   = io.tile_req & enable_mask;
    pick       = rr_pick(eligible, ptr);
    pick_found = pick[SEL_W];
    pick_idx   = pick[SEL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_r       <= '0;
      ptr         <= SEL_W'(N_TILES - 1);
      prep_cnt    <= '0;
      dwell_cnt   <= '0;
      dwell_len   <= DWELL_W'(16);
      enable_mask <= '1;
      bus_p1      <= 8'h00;
    end else begin
      // p1: pad bus registered from the tile selected during RUN
      bus_p1 <= (state == RUN) ? io.tile_out[{sel_r, 3'b000} +: 8] : 8'h00;

      // Config writes only touch the stored values; live counters reload later.
      if (io.cfg_we) begin
        case (io.cfg_addr)
          2'd0:    dwell_len   <= clamp_dwell(io.cfg_wdata);
          2'd1:    enable_mask <= io.cfg_wdata[N_TILES-1:0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= PREP;
            sel_r    <= pick_idx;
            ptr      <= pick_idx;
            prep_cnt <= PC_W'(PREP_CYCLES - 1);
          end
        end
        PREP: begin
          if (!eligible[sel_r]) begin
            state <= IDLE;
          end else if (prep_cnt == '0) begin
            state     <= RUN;
            dwell_cnt <= dwell_len;
          end else begin
            prep_cnt <= prep_cnt - 1'b1;
          end
        end
        RUN: begin
          // A dropped request or an expiry with a competitor ends the slice.
          if (!eligible[sel_r] ||
              (dwell_cnt == DWELL_W'(1) && pick_found && pick_idx != sel_r)) begin
            if (pick_found) begin
              state    <= PREP;
              sel_r    <= pick_idx;
              ptr      <= pick_idx;
              prep_cnt <= PC_W'(PREP_CYCLES - 1);
            end else begin
              state <= IDLE;
            end
          end else if (dwell_cnt == DWELL_W'(1)) begin
            dwell_cnt <= dwell_len;
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.sel        = sel_r;
  assign io.busy       = (state != IDLE);
  assign io.tile_grant = (state != IDLE) ? (N_TILES'(1) << sel_r) : '0;
  assign io.tile_rst   = (state == RUN) ? ~(N_TILES'(1) << sel_r) : '1;
  assign io.bus_out    = bus_p1;
endmodule

// File: tb/tb_micro_tile_scheduler.sv
// Self-checking bench for micro_tile_scheduler: directed scenarios plus random
// traffic compared every cycle against a slice-level behavioural model.
module tb_micro_tile_scheduler;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  micro_tile_scheduler_if #(.N_TILES(N)) io ();

  micro_tile_scheduler #(.N_TILES(N), .DWELL_W(DW), .PREP_CYCLES(PC)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 = idle, 1 = preparing, 2 = running; m_left = cycles left in phase.
  int         m_phase;
  int         m_sel;
  int         m_ptr;
  int         m_left;
  int         m_dwell;
  logic [N-1:0] m_mask;
  logic [7:0] m_bus;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sel = 0; m_ptr = N - 1; m_left = 0;
    m_dwell = 16; m_mask = '1; m_bus = 8'h00;
  endtask

  task automatic start_prep(input int t);
    m_phase = 1; m_sel = t; m_ptr = t; m_left = PC;
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    logic [7:0]   nbus;
    int           pk;
    if (rst) begin
      model_reset();
      return;
    end
    elig = io.tile_req & m_mask;
    nbus = (m_phase == 2) ? io.tile_out[8*m_sel +: 8] : 8'h00;
    case (m_phase)
      0: begin
        pk = rr(elig, m_ptr);
        if (pk >= 0) start_prep(pk);
      end
      1: begin
        if (!elig[m_sel]) m_phase = 0;
        else if (m_left == 1) begin m_phase = 2; m_left = m_dwell; end
        else m_left--;
      end
      default: begin
        if (!elig[m_sel]) begin
          pk = rr(elig, m_ptr);
          if (pk >= 0) start_prep(pk); else m_phase = 0;
        end else if (m_left == 1) begin
          pk = rr(elig, m_ptr);
          if (pk != m_sel) start_prep(pk); else m_left = m_dwell;
        end else m_left--;
      end
    endcase
    if (io.cfg_we) begin
      if (io.cfg_addr == 2'd0) m_dwell = (io.cfg_wdata == 8'd0) ? 1 : int'(io.cfg_wdata);
      if (io.cfg_addr == 2'd1) m_mask = io.cfg_wdata[N-1:0];
    end
    m_bus = nbus;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg = '0;
    er = '1;
    if (m_phase != 0) eg[m_sel] = 1'b1;
    if (m_phase == 2) er[m_sel] = 1'b0;
    chk("tile_grant", 32'(io.tile_grant), 32'(eg));
    chk("tile_rst",   32'(io.tile_rst),   32'(er));
    chk("sel",        32'(io.sel),        32'(m_sel));
    chk("busy",       32'(io.busy),       32'(m_phase != 0));
    chk("bus_out",    32'(io.bus_out),    32'(m_bus));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    io.cfg_we = 1'b0;
    rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg(input logic [1:0] a, input logic [7:0] d);
    io.cfg_we = 1'b1; io.cfg_addr = a; io.cfg_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    logic [N-1:0] grants[$];
    logic [N-1:0] prev;
    logic [N-1:0] exp_order [4];
    int           guard;

    rst = 1'b1;
    io.cfg_we = 1'b0; io.cfg_addr = 2'd0; io.cfg_wdata = 8'd0;
    io.tile_req = '0; io.tile_out = {8'h44, 8'h33, 8'h22, 8'hA5};
    model_reset();
    cycle();

    // Reset values and an idle stretch
    chk("rst_grant", 32'(io.tile_grant), 32'h0);
    chk("rst_trst",  32'(io.tile_rst),   32'hF);
    chk("rst_busy",  32'(io.busy),       32'h0);
    chk("rst_bus",   32'(io.bus_out),    32'h0);
    cycles(20);

    // Two requesters alternate with dwell 3
    cfg(2'd0, 8'd3); cycle();
    io.tile_req = 4'b0101;
    cycle();
    chk("rr_first_grant", 32'(io.tile_grant), 32'h1);
    chk("rr_prep_trst",   32'(io.tile_rst),   32'hF);
    cycles(2);
    chk("rr_run_trst",    32'(io.tile_rst),   32'hE);
    chk("rr_run_bus0",    32'(io.bus_out),    32'h0);
    cycle();
    chk("rr_run_busA5",   32'(io.bus_out),    32'hA5);
    cycles(2);
    chk("rr_second_grant", 32'(io.tile_grant), 32'h4);
    cycles(25);

    // Single requester keeps running without re-prep
    do_reset();
    cfg(2'd0, 8'd4); cycle();
    io.tile_req = 4'b0001;
    cycles(30);
    chk("solo_trst", 32'(io.tile_rst), 32'hE);
    chk("solo_bus",  32'(io.bus_out),  32'hA5);

    // Enable mask restricts grants to tiles 1 and 3
    do_reset();
    cfg(2'd1, 8'h0A); cycle();
    cfg(2'd0, 8'd2); cycle();
    io.tile_req = 4'b1111;
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (io.tile_grant != '0 && io.tile_grant != prev) grants.push_back(io.tile_grant);
      prev = io.tile_grant;
    end
    exp_order[0] = 4'b0010; exp_order[1] = 4'b1000;
    exp_order[2] = 4'b0010; exp_order[3] = 4'b1000;
    for (int i = 0; i < 4; i++)
      chk("mask_order", (i < grants.size()) ? 32'(grants[i]) : 32'h0, 32'(exp_order[i]));

    // Request drop mid-RUN
    do_reset();
    io.tile_req = 4'b0010;
    cycles(4);
    io.tile_req = 4'b0000;
    cycle();
    chk("drop_busy",  32'(io.busy),       32'h0);
    chk("drop_grant", 32'(io.tile_grant), 32'h0);
    cycle();
    chk("drop_bus",   32'(io.bus_out),    32'h0);

    // Reset mid-RUN
    io.tile_req = 4'b0010;
    cycles(5);
    rst = 1'b1;
    cycle();
    chk("mrst_grant", 32'(io.tile_grant), 32'h0);
    chk("mrst_trst",  32'(io.tile_rst),   32'hF);
    chk("mrst_sel",   32'(io.sel),        32'h0);
    chk("mrst_bus",   32'(io.bus_out),    32'h0);

    // Dwell 0 acts as 1
    cfg(2'd0, 8'd0); cycle();
    io.tile_req = 4'b0101;
    cycles(20);

    // Dwell write on the reload cycle affects only the following slice
    do_reset();
    cfg(2'd0, 8'd2); cycle();
    io.tile_req = 4'b0001;
    guard = 0;
    while (!(m_phase == 2 && m_left == 1) && guard < 50) begin
      cycle();
      guard++;
    end
    chk("reload_reached", 32'(guard < 50), 32'h1);
    cfg(2'd0, 8'd5); cycle();
    chk("reload_old_len", 32'(m_left), 32'd2);
    cycles(2);
    chk("reload_new_len", 32'(m_left), 32'd5);
    cycles(6);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      io.tile_req = N'($urandom);
      io.tile_out = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        io.cfg_we   = 1'b1;
        io.cfg_addr = 2'($urandom_range(0, 3));
        io.cfg_wdata = (io.cfg_addr == 2'd0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
